// File: rtl/countdown_timer.sv
// BCD minutes:seconds countdown timer with IDLE/RUN/PAUSE/EXPIRED control.
// Optional low-time warning output enabled by defining COUNTDOWN_WARN_EN.
module countdown_timer #(
    parameter int CLK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] preset_m,
    input  logic [7:0] preset_s,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] m,
    output logic [7:0] s,
    output logic       running,
    output logic       done,
    output logic       expired,
    output logic       warn
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

    localparam int            PW   = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);

    state_t        state, state_n;
    logic [PW-1:0] presc, presc_n;
    logic [3:0]    m_n;
    logic [7:0]    s_n;
    logic          tick;

    function automatic logic [3:0] sat(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    assign tick = (state == RUN) && (presc == PMAX);

    always_comb begin
        state_n = state;
        presc_n = presc;
        m_n     = m;
        s_n     = s;
        if (state == RUN)
            presc_n = tick ? '0 : presc + 1'b1;
        // One-second BCD decrement with borrow; 00:00 never occurs in RUN.
        if (tick) begin
            if (s[3:0] != 4'd0)
                s_n[3:0] = s[3:0] - 4'd1;
            else if (s[7:4] != 4'd0)
                s_n = {s[7:4] - 4'd1, 4'd9};
            else if (m != 4'd0) begin
                m_n = m - 4'd1;
                s_n = 8'h59;
            end
        end
        if (load) begin
            m_n     = sat(preset_m, 4'd9);
            s_n     = {sat(preset_s[7:4], 4'd5), sat(preset_s[3:0], 4'd9)};
            state_n = IDLE;
            presc_n = '0;
        end else begin
            case (state)
                IDLE:
                    if (start && (m != 4'd0 || s != 8'h00)) begin
                        state_n = RUN;
                        presc_n = '0;
                    end
                RUN:
                    if (tick && m_n == 4'd0 && s_n == 8'h00)
                        state_n = EXPIRED;
                    else if (pause)
                        state_n = PAUSE;
                PAUSE:
                    if (start && !pause)
                        state_n = RUN;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            presc   <= '0;
            m       <= 4'd0;
            s       <= 8'h00;
            running <= 1'b0;
            done    <= 1'b0;
            expired <= 1'b0;
        end else begin
            state   <= state_n;
            presc   <= presc_n;
            m       <= m_n;
            s       <= s_n;
            running <= (state_n == RUN);
            expired <= (state_n == EXPIRED);
            done    <= (state == RUN) && (state_n == EXPIRED);
        end
    end

`ifdef COUNTDOWN_WARN_EN
    always_ff @(posedge clk) begin
        if (reset)
            warn <= 1'b0;
        else
            warn <= (state_n == RUN || state_n == PAUSE) && m_n == 4'd0 && s_n <= 8'h10;
    end
`else
    assign warn = 1'b0;
`endif

endmodule
